key_sequence_encoder: RTL and testbench

//  Inverse of the calculator key decoder: turns a 32-bit two's-complement value into the

---
 rtl/key_sequence_encoder.sv | 229 ++++++++++++++++++++++
 tb/tb_key_sequence_encoder.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_sequence_encoder.sv
// key_sequence_encoder
// Converts a 32-bit two's-complement value into the numpad key-code stream
// that enters that value into the calculator core: decimal digits MSB first,
// then F (unary minus) for negative values, then optionally A (=, push).
// Each key is held for HOLD_CYCLES clocks, followed by GAP_CYCLES idle clocks
// so the core always sees a release between keys.

module key_sequence_encoder #(
  parameter int HOLD_CYCLES = 1,
  parameter int GAP_CYCLES  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] value,
  input  logic        push_after,
  output logic [4:0]  code,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONVERT = 3'd1,
    S_SKIP    = 3'd2,
    S_HOLD    = 3'd3,
    S_GAP     = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // Which part of the key stream is currently being sent.
  typedef enum logic [1:0] {
    K_DIGIT  = 2'd0,
    K_MINUS  = 2'd1,
    K_EQUALS = 2'd2
  } slot_t;

  localparam logic [4:0]  KEY_A     = 5'b11100;
  localparam logic [4:0]  KEY_F     = 5'b10111;
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

  state_t      r_state;
  slot_t       r_slot;
  logic [31:0] r_raw;
  logic        r_neg;
  logic        r_push;
  logic [31:0] r_bin;
  logic [39:0] r_bcd;
  logic [15:0] r_cnt;
  logic [3:0]  r_idx;
  logic [4:0]  r_code;
  logic        r_busy;
  logic        r_done;

  logic [39:0] w_adj;
  logic [71:0] w_shifted;
  logic [3:0]  w_msd;
  logic [3:0]  w_msd_digit;
  logic [3:0]  w_idx_dn;
  logic [3:0]  w_digit_dn;

  // Double-dabble correction: add 3 to every BCD digit that is 5 or more.
  function automatic logic [39:0] bcd_adjust(input logic [39:0] bcd);
    logic [39:0] res;
    logic [3:0]  d;
    res = bcd;
    for (int i = 0; i < 10; i++) begin
      d = bcd[4*i +: 4];
      res[4*i +: 4] = (d >= 4'd5) ? (d + 4'd3) : d;
    end
    return res;
  endfunction

  // Numpad code of a decimal digit, identical to the core's key map.
  function automatic logic [4:0] key_of_digit(input logic [3:0] d);
    logic [4:0] k;
    case (d)
      4'd0:    k = 5'b10011;
      4'd1:    k = 5'b10000;
      4'd2:    k = 5'b10100;
      4'd3:    k = 5'b11000;
      4'd4:    k = 5'b10001;
      4'd5:    k = 5'b10101;
      4'd6:    k = 5'b11001;
      4'd7:    k = 5'b10010;
      4'd8:    k = 5'b10110;
      4'd9:    k = 5'b11010;
      default: k = 5'b00000;
    endcase
    return k;
  endfunction

  assign w_adj     = bcd_adjust(r_bcd);
  assign w_shifted = {w_adj, r_bin} << 1;
  assign w_idx_dn  = r_idx - 4'd1;

  // Priority-encode the most significant nonzero BCD digit (all-zero -> digit 0).
  always_comb begin
    w_msd       = 4'd0;
    w_msd_digit = r_bcd[3:0];
    for (int i = 1; i < 10; i++) begin
      w_msd       = (r_bcd[4*i +: 4] != 4'd0) ? 4'(i) : w_msd;
      w_msd_digit = (r_bcd[4*i +: 4] != 4'd0) ? r_bcd[4*i +: 4] : w_msd_digit;
    end
  end

  // Select the next digit toward the LSB for the following key slot.
  always_comb begin
    w_digit_dn = 4'd0;
    for (int i = 0; i < 10; i++) begin
      w_digit_dn = (w_idx_dn == 4'(i)) ? r_bcd[4*i +: 4] : w_digit_dn;
    end
  end

  // Main sequencer: latch, convert, then play keys with hold/gap timing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_slot  <= K_DIGIT;
      r_raw   <= 32'd0;
      r_neg   <= 1'b0;
      r_push  <= 1'b0;
      r_bin   <= 32'd0;
      r_bcd   <= 40'd0;
      r_cnt   <= 16'd0;
      r_idx   <= 4'd0;
      r_code  <= 5'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_code <= 5'd0;
          r_done <= 1'b0;
          if (start) begin
            r_raw   <= value;
            r_neg   <= value[31];
            r_push  <= push_after;
            r_cnt   <= 16'd0;
            r_busy  <= 1'b1;
            r_state <= S_CONVERT;
          end else begin
            r_busy  <= 1'b0;
          end
        end

        // Step 0 forms the magnitude (keeps the negator off the input path);
        // steps 1..32 are the double-dabble shifts.
        S_CONVERT: begin
          if (r_cnt == 16'd0) begin
            r_bin <= r_neg ? (32'd0 - r_raw) : r_raw;
            r_bcd <= 40'd0;
          end else begin
            {r_bcd, r_bin} <= w_shifted;
          end
          if (r_cnt == 16'd32) begin
            r_cnt   <= 16'd0;
            r_state <= S_SKIP;
          end else begin
            r_cnt   <= r_cnt + 16'd1;
          end
        end

        S_SKIP: begin
          r_idx   <= w_msd;
          r_slot  <= K_DIGIT;
          r_code  <= key_of_digit(w_msd_digit);
          r_cnt   <= 16'd0;
          r_state <= S_HOLD;
        end

        S_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            r_code  <= 5'd0;
            r_cnt   <= 16'd0;
            r_state <= S_GAP;
          end else begin
            r_cnt   <= r_cnt + 16'd1;
          end
        end

        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt <= 16'd0;
            if ((r_slot == K_DIGIT) && (r_idx != 4'd0)) begin
              r_idx   <= w_idx_dn;
              r_code  <= key_of_digit(w_digit_dn);
              r_state <= S_HOLD;
            end else if ((r_slot == K_DIGIT) && r_neg) begin
              r_slot  <= K_MINUS;
              r_code  <= KEY_F;
              r_state <= S_HOLD;
            end else if ((r_slot != K_EQUALS) && r_push) begin
              r_slot  <= K_EQUALS;
              r_code  <= KEY_A;
              r_state <= S_HOLD;
            end else begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        // Start is deliberately not sampled here.
        S_DONE: begin
          r_done  <= 1'b0;
          r_code  <= 5'd0;
          r_state <= S_IDLE;
        end

        default: begin
          r_code  <= 5'd0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign code = r_code;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_key_sequence_encoder.sv
// Directed bench for key_sequence_encoder with a small calculator-core model
// that rebuilds the entered value from the key stream.

module tb_key_sequence_encoder;

  localparam int HOLD = 1;
  localparam int GAP  = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] value = 32'd0;
  logic        push_after = 1'b0;
  logic [4:0]  code;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  key_sequence_encoder #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .clock(clock), .reset(reset), .start(start), .value(value),
    .push_after(push_after), .code(code), .busy(busy), .done(done)
  );

  always #10 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- core model / stream monitor ----------------
  logic [4:0]  q_keys[$];
  logic [31:0] m_entry = 32'd0;
  logic [31:0] m_top = 32'd0;
  logic [4:0]  m_prev = 5'd0;
  logic        m_prev_busy = 1'b0;
  logic        m_have_prev = 1'b0;
  int          m_run = 0;
  int          m_zeros = 0;
  int          hold_err = 0;
  int          gap_err = 0;

  function automatic logic [31:0] model_step(input logic [31:0] acc, input logic [4:0] k);
    case (k)
      5'b10011: return acc * 32'd10 + 32'd0;
      5'b10000: return acc * 32'd10 + 32'd1;
      5'b10100: return acc * 32'd10 + 32'd2;
      5'b11000: return acc * 32'd10 + 32'd3;
      5'b10001: return acc * 32'd10 + 32'd4;
      5'b10101: return acc * 32'd10 + 32'd5;
      5'b11001: return acc * 32'd10 + 32'd6;
      5'b10010: return acc * 32'd10 + 32'd7;
      5'b10110: return acc * 32'd10 + 32'd8;
      5'b11010: return acc * 32'd10 + 32'd9;
      5'b10111: return 32'd0 - acc;
      default:  return acc;
    endcase
  endfunction

  function automatic logic [4:0] sym_code(input byte c);
    case (c)
      "0": return 5'b10011;
      "1": return 5'b10000;
      "2": return 5'b10100;
      "3": return 5'b11000;
      "4": return 5'b10001;
      "5": return 5'b10101;
      "6": return 5'b11001;
      "7": return 5'b10010;
      "8": return 5'b10110;
      "9": return 5'b11010;
      "A": return 5'b11100;
      "F": return 5'b10111;
      default: return 5'b00000;
    endcase
  endfunction

  always @(negedge clock) begin
    if (reset) begin
      m_prev      <= 5'd0;
      m_prev_busy <= 1'b0;
      m_have_prev <= 1'b0;
      m_run       <= 0;
      m_zeros     <= 0;
    end else begin
      m_prev_busy <= busy;
      m_prev      <= code;
      if (busy && !m_prev_busy) begin
        m_entry <= 32'd0;
        m_top   <= 32'd0;
      end else if (code != 5'd0 && m_prev == 5'd0) begin
        if (m_have_prev && m_zeros < GAP) gap_err <= gap_err + 1;
        q_keys.push_back(code);
        m_entry <= model_step(m_entry, code);
        if (code == 5'b11100) m_top <= m_entry;
        m_run <= 1;
      end else if (code != 5'd0) begin
        if (code != m_prev) gap_err <= gap_err + 1;
        m_run <= m_run + 1;
      end else if (m_prev != 5'd0) begin
        if (m_run != HOLD) hold_err <= hold_err + 1;
        m_have_prev <= 1'b1;
        m_zeros     <= 1;
      end else begin
        m_zeros <= m_zeros + 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start(input logic [31:0] v, input logic p, output int t_n);
    @(negedge clock);
    start = 1'b1; value = v; push_after = p;
    t_n = cyc + 1;
    @(negedge clock);
    start = 1'b0; value = ~v; push_after = ~p;
  endtask

  task automatic wait_done(output int done_cyc, output int first_cyc);
    done_cyc = -1;
    first_cyc = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock); #1;
      if (code != 5'd0 && first_cyc < 0) first_cyc = cyc;
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clock);
    #1;
    n_checks++;
    if (code !== 5'd0) begin n_errors++; $display("FAIL reset_code got=%b want=00000", code); end
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got=%b want=0", done); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_zero();
    int tn, dc, fc, base, nbusy;
    base = q_keys.size();
    pulse_start(32'd0, 1'b0, tn);
    wait_done(dc, fc);
    n_checks++;
    if (fc != tn + 34) begin n_errors++; $display("FAIL zero_first_key got=%0d want=%0d", fc - tn, 34); end
    n_checks++;
    if (dc != tn + 37) begin n_errors++; $display("FAIL zero_done_time got=%0d want=%0d", dc - tn, 37); end
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL zero_busy_at_done got=%b want=0", busy); end
    n_checks++;
    if (q_keys.size() != base + 1) begin
      n_errors++; $display("FAIL zero_key_count got=%0d want=1", q_keys.size() - base);
    end else if (q_keys[base] !== 5'b10011) begin
      n_errors++; $display("FAIL zero_key got=%b want=10011", q_keys[base]);
    end
    // start while in DONE must be ignored
    start = 1'b1; value = 32'd5; push_after = 1'b0;
    @(negedge clock); #1;
    start = 1'b0;
    n_checks++;
    if (done !== 1'b0) begin n_errors++; $display("FAIL zero_done_width got=%b want=0", done); end
    nbusy = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock); #1;
      if (busy) nbusy++;
    end
    n_checks++;
    if (nbusy != 0) begin n_errors++; $display("FAIL start_in_done busy_cycles got=%0d want=0", nbusy); end
  endtask

  task automatic test_sequences();
    logic [31:0] tv[7];
    logic        tp[7];
    string       ts[7];
    int tn, dc, fc, base, he, ge;
    tv[0] = 32'd407;        tp[0] = 1'b1; ts[0] = "407A";
    tv[1] = 32'hFFFFFFE7;   tp[1] = 1'b0; ts[1] = "25F";
    tv[2] = 32'h80000000;   tp[2] = 1'b0; ts[2] = "2147483648F";
    tv[3] = 32'hFFFFFFFF;   tp[3] = 1'b0; ts[3] = "1F";
    tv[4] = 32'd2147483647; tp[4] = 1'b1; ts[4] = "2147483647A";
    tv[5] = 32'd1000000000; tp[5] = 1'b0; ts[5] = "1000000000";
    tv[6] = 32'hFFFFFFF6;   tp[6] = 1'b1; ts[6] = "10FA";
    he = hold_err; ge = gap_err;
    for (int t = 0; t < 7; t++) begin
      base = q_keys.size();
      pulse_start(tv[t], tp[t], tn);
      wait_done(dc, fc);
      n_checks++;
      if (dc != tn + 34 + 3 * ts[t].len())
        begin n_errors++; $display("FAIL seq%0d_done_time got=%0d want=%0d", t, dc - tn, 34 + 3 * ts[t].len()); end
      n_checks++;
      if (q_keys.size() - base != ts[t].len()) begin
        n_errors++; $display("FAIL seq%0d_key_count got=%0d want=%0d", t, q_keys.size() - base, ts[t].len());
      end else begin
        for (int k = 0; k < ts[t].len(); k++) begin
          n_checks++;
          if (q_keys[base + k] !== sym_code(ts[t][k])) begin
            n_errors++; $display("FAIL seq%0d_key%0d got=%b want=%b", t, k, q_keys[base + k], sym_code(ts[t][k]));
          end
        end
      end
      n_checks++;
      if (m_entry !== tv[t]) begin n_errors++; $display("FAIL seq%0d_core_entry got=%h want=%h", t, m_entry, tv[t]); end
      if (tp[t]) begin
        n_checks++;
        if (m_top !== tv[t]) begin n_errors++; $display("FAIL seq%0d_core_top got=%h want=%h", t, m_top, tv[t]); end
      end
    end
    n_checks++;
    if (hold_err != he || gap_err != ge)
      begin n_errors++; $display("FAIL seq_timing hold_err=%0d gap_err=%0d want=0", hold_err - he, gap_err - ge); end
  endtask

  task automatic test_ignore_start();
    int tn, dc, fc, base, nb, nbusy;
    base = q_keys.size();
    pulse_start(32'd58, 1'b0, tn);
    nb = 0;
    for (int i = 0; i < 20 && nb < 5; i++) begin
      @(negedge clock); #1;
      if (busy) nb++;
    end
    start = 1'b1; value = 32'd999; push_after = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(dc, fc);
    n_checks++;
    if (dc != tn + 40) begin n_errors++; $display("FAIL ignore_done_time got=%0d want=40", dc - tn); end
    n_checks++;
    if (q_keys.size() != base + 2 || q_keys[base] !== 5'b10101 || q_keys[base + 1] !== 5'b10110) begin
      n_errors++; $display("FAIL ignore_keys got_count=%0d want=2 keys 10101 10110", q_keys.size() - base);
    end
    n_checks++;
    if (m_entry !== 32'd58) begin n_errors++; $display("FAIL ignore_core_entry got=%0d want=58", m_entry); end
    nbusy = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock); #1;
      if (busy) nbusy++;
    end
    n_checks++;
    if (nbusy != 0 || q_keys.size() != base + 2)
      begin n_errors++; $display("FAIL ignore_no_second_run busy_cycles=%0d extra_keys=%0d want=0", nbusy, q_keys.size() - base - 2); end
  endtask

  task automatic test_reset_mid();
    int tn, dc, fc, base, ndone;
    bit found;
    base = q_keys.size();
    pulse_start(32'd407, 1'b1, tn);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock); #1;
      if (q_keys.size() == base + 2) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found) begin n_errors++; $display("FAIL rstmid_reach_hold2 got=no want=yes"); end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (code !== 5'd0) begin n_errors++; $display("FAIL rstmid_code got=%b want=00000", code); end
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    @(negedge clock);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock); #1;
      if (done || busy || code != 5'd0) ndone++;
    end
    n_checks++;
    if (ndone != 0) begin n_errors++; $display("FAIL rstmid_quiet active_cycles=%0d want=0", ndone); end
    base = q_keys.size();
    pulse_start(32'd9, 1'b0, tn);
    wait_done(dc, fc);
    n_checks++;
    if (dc != tn + 37) begin n_errors++; $display("FAIL rstmid_restart_time got=%0d want=37", dc - tn); end
    n_checks++;
    if (q_keys.size() != base + 1 || q_keys[base] !== 5'b11010)
      begin n_errors++; $display("FAIL rstmid_restart_keys count=%0d want=1 key 11010", q_keys.size() - base); end
    n_checks++;
    if (m_entry !== 32'd9) begin n_errors++; $display("FAIL rstmid_core_entry got=%0d want=9", m_entry); end
  endtask

  task automatic test_random();
    int tn, dc, fc, he, ge;
    logic [31:0] v;
    he = hold_err; ge = gap_err;
    for (int r = 0; r < 300; r++) begin
      v = $urandom >> $urandom_range(0, 28);
      if ($urandom_range(0, 1) == 1) v = 32'd0 - v;
      pulse_start(v, 1'b1, tn);
      wait_done(dc, fc);
      n_checks++;
      if (dc < 0 || m_top !== v) begin
        n_errors++; $display("FAIL random%0d_core_top got=%h want=%h done_cyc=%0d", r, m_top, v, dc);
      end
    end
    n_checks++;
    if (hold_err != he || gap_err != ge)
      begin n_errors++; $display("FAIL random_timing hold_err=%0d gap_err=%0d want=0", hold_err - he, gap_err - ge); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_sequences();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
